// File: rtl/demux_pkg.sv
// Shared definitions for the 3-channel TDM receive demultiplexer.
// Optional feature macro: DEMUX_ERR_CNT_EN (saturating frame-error counter).
package demux_pkg;

  localparam int NCH_DEF   = 3;
  localparam int WIDTH_DEF = 2;
  localparam int SLOT_W    = $clog2(NCH_DEF);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } demux_state_t;

  // Eight-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter for the TDM receiver: clear, restart-at-one (for a new
// start-of-frame beat) and increment, with a flag for the final slot.
module tdm_slot_cnt
  import demux_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [SW-1:0] slot,
  output logic          last
);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  // Next slot value: clear wins over restart, restart wins over increment.
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SW'(1);
    end else if (inc) begin
      slot_d = slot_q + SW'(1);
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == SW'(NCH - 1));

endmodule

// File: rtl/demux3_tdm_rx.sv
// Receive side of the 3-channel TDM link: collects sof-framed beats into a
// shadow buffer and publishes each complete frame to registered outputs.
// Optional feature macro: DEMUX_ERR_CNT_EN adds a saturating err_cnt output.
module demux3_tdm_rx
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NCH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y_a,
  output logic [WIDTH-1:0] y_b,
  output logic [WIDTH-1:0] y_c,
  output logic             out_valid,
  output logic             frame_err
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam int SW = $clog2(NCH);

  demux_state_t   state_q, state_d;
  // Only slots 0..NCH-2 need buffering; the last beat goes straight out.
  logic [WIDTH-1:0] shadow_q [NCH-1];
  logic [WIDTH-1:0] shadow_d [NCH-1];
  logic [WIDTH-1:0] y_a_q, y_a_d, y_b_q, y_b_d, y_c_q, y_c_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;

  logic             cnt_clr_s, cnt_load1_s, cnt_inc_s;
  logic [SW-1:0]    slot_s;
  logic             slot_last_s;

  tdm_slot_cnt #(
    .NCH (NCH),
    .SW  (SW)
  ) u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .load1 (cnt_load1_s),
    .inc   (cnt_inc_s),
    .slot  (slot_s),
    .last  (slot_last_s)
  );

  // Frame FSM: next state, shadow capture, output publication and pulses.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    y_a_d       = y_a_q;
    y_b_d       = y_b_q;
    y_c_d       = y_c_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_load1_s = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid && sof) begin
          shadow_d[0] = din;
          cnt_load1_s = 1'b1;
          state_d     = COLLECT;
        end else begin
          // Beats without sof are dropped silently while idle.
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (din_valid) begin
          if (sof) begin
            // Early start: abandon the partial frame, restart at slot 0.
            frame_err_d = 1'b1;
            shadow_d[0] = din;
            cnt_load1_s = 1'b1;
            state_d     = COLLECT;
          end else if (slot_last_s) begin
            y_a_d       = shadow_q[0];
            y_b_d       = shadow_q[1];
            y_c_d       = din;
            out_valid_d = 1'b1;
            cnt_clr_s   = 1'b1;
            state_d     = IDLE;
          end else begin
            for (int i = 0; i < NCH - 1; i++) begin
              if (slot_s == SW'(i)) begin
                shadow_d[i] = din;
              end else begin
                shadow_d[i] = shadow_q[i];
              end
            end
            cnt_inc_s = 1'b1;
            state_d   = COLLECT;
          end
        end else begin
          // Stall: everything holds, no timeout.
          state_d = COLLECT;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < NCH - 1; i++) begin
        shadow_q[i] <= '0;
      end
      y_a_q       <= '0;
      y_b_q       <= '0;
      y_c_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      y_a_q       <= y_a_d;
      y_b_q       <= y_b_d;
      y_c_q       <= y_c_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign y_a       = y_a_q;
  assign y_b       = y_b_q;
  assign y_c       = y_c_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of broken frames, updated on the edge that raises frame_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (frame_err_d) begin
      err_cnt_q <= sat_inc8(err_cnt_q);
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux3_tdm_rx.sv
// Self-checking bench for demux3_tdm_rx: directed steps from the test plan
// plus a random beat stream, checked against a queue-based frame model.
module tb_demux3_tdm_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] din;
  logic       din_valid;
  logic       sof;
  logic [1:0] y_a, y_b, y_c;
  logic       out_valid;
  logic       frame_err;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  demux3_tdm_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sof       (sof),
    .y_a       (y_a),
    .y_b       (y_b),
    .y_c       (y_c),
    .out_valid (out_valid),
    .frame_err (frame_err)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: beats of the frame in progress, last published frame.
  logic [1:0] pend[$];
  logic [1:0] m_ya, m_yb, m_yc;
  logic       m_ov, m_fe;
  int         m_err;

  task automatic model_reset();
    pend.delete();
    m_ya = 2'd0; m_yb = 2'd0; m_yc = 2'd0;
    m_ov = 1'b0; m_fe = 1'b0;
    m_err = 0;
  endtask

  // One accepted-or-not edge as seen by the frame rules.
  task automatic model_edge(input logic v, input logic s, input logic [1:0] d);
    m_ov = 1'b0;
    m_fe = 1'b0;
    if (v) begin
      if (s) begin
        if (pend.size() > 0) begin
          m_fe = 1'b1;
          if (m_err < 255) m_err++;
        end
        pend.delete();
        pend.push_back(d);
      end else if (pend.size() > 0) begin
        pend.push_back(d);
        if (pend.size() == 3) begin
          m_ya = pend[0]; m_yb = pend[1]; m_yc = pend[2];
          m_ov = 1'b1;
          pend.delete();
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y_a"}, 8'(y_a), 8'(m_ya));
    chk({tag, ".y_b"}, 8'(y_b), 8'(m_yb));
    chk({tag, ".y_c"}, 8'(y_c), 8'(m_yc));
    chk({tag, ".out_valid"}, 8'(out_valid), 8'(m_ov));
    chk({tag, ".frame_err"}, 8'(frame_err), 8'(m_fe));
`ifdef DEMUX_ERR_CNT_EN
    chk({tag, ".err_cnt"}, err_cnt, 8'(m_err));
`endif
  endtask

  // Present one cycle of input, let the edge happen, then check outputs.
  task automatic step(input string tag, input logic v, input logic s, input logic [1:0] d);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    model_edge(v, s, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 2'd0;
    model_reset();

    // Reset held: all outputs zero.
    #12;
    check_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, 2'd0);

    // Single frame, no gaps.
    step("f1_b0", 1'b1, 1'b1, 2'd0);
    step("f1_b1", 1'b1, 1'b0, 2'd1);
    step("f1_b2", 1'b1, 1'b0, 2'd2);
    step("f1_after", 1'b0, 1'b0, 2'd0);

    // Stalled frame: prior outputs hold until completion.
    step("st_b0", 1'b1, 1'b1, 2'd3);
    step("st_gap", 1'b0, 1'b0, 2'd0);
    step("st_gap", 1'b0, 1'b1, 2'd1);
    step("st_b1", 1'b1, 1'b0, 2'd1);
    step("st_gap", 1'b0, 1'b0, 2'd3);
    step("st_b2", 1'b1, 1'b0, 2'd2);
    step("st_after", 1'b0, 1'b0, 2'd0);

    // Back-to-back full-rate frames.
    for (int f = 0; f < 3; f++) begin
      step("b2b_b0", 1'b1, 1'b1, 2'(f));
      step("b2b_b1", 1'b1, 1'b0, 2'(f + 1));
      step("b2b_b2", 1'b1, 1'b0, 2'(f + 2));
    end

    // Early sof.
    step("es_b0", 1'b1, 1'b1, 2'd1);
    step("es_b1", 1'b1, 1'b0, 2'd2);
    step("es_sof", 1'b1, 1'b1, 2'd0);
    step("es_b3", 1'b1, 1'b0, 2'd3);
    step("es_b4", 1'b1, 1'b0, 2'd1);
    step("es_after", 1'b0, 1'b0, 2'd0);

    // Junk without sof while idle is dropped.
    step("junk", 1'b1, 1'b0, 2'd3);
    step("junk", 1'b1, 1'b0, 2'd2);

    // Reset in the middle of a frame clears outputs without a clock edge.
    step("mr_b0", 1'b1, 1'b1, 2'd1);
    step("mr_b1", 1'b1, 1'b0, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("pr_junk", 1'b1, 1'b0, 2'd1);
    step("pr_b0", 1'b1, 1'b1, 2'd2);
    step("pr_b1", 1'b1, 1'b0, 2'd2);
    step("pr_b2", 1'b1, 1'b0, 2'd2);

    // Random beat stream.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 75), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)));
    end

    // Error storm: one opening sof followed by 300 early sofs.
    step("storm_open", 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 300; i++) step("storm", 1'b1, 1'b1, 2'($urandom_range(0, 3)));
    step("storm_b1", 1'b1, 1'b0, 2'd1);
    step("storm_b2", 1'b1, 1'b0, 2'd3);
    step("storm_end", 1'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
